// File: rtl/pattern_loader_pkg.sv
// Shared types and helpers for the pattern frame loader.
//   state_t      : loader FSM states
//   chan_t       : colour channel written by a LOAD step (G, R, B in rotation)
//   pixel_grb_t  : one 24-bit GRB pixel, G in the most significant byte
//   NUM_ENTRIES  : depth of the colour / pixel step arrays
package pattern_loader_pkg;

    localparam int NUM_ENTRIES = 63;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SEND  = 3'd2,
        GAP   = 3'd3,
        CLEAR = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        CH_G = 2'd0,
        CH_R = 2'd1,
        CH_B = 2'd2
    } chan_t;

    typedef struct packed {
        logic [7:0] g;
        logic [7:0] r;
        logic [7:0] b;
    } pixel_grb_t;

    // Steps per pattern cycle: zero still plays one step, and anything past
    // the array depth is capped so the index never leaves the arrays.
    function automatic logic [6:0] effective_limit(input logic [6:0] max_loads);
        if (max_loads == 7'd0) begin
            return 7'd1;
        end
        if (max_loads > 7'(NUM_ENTRIES)) begin
            return 7'(NUM_ENTRIES);
        end
        return max_loads;
    endfunction

    function automatic chan_t next_chan(input chan_t ch);
        case (ch)
            CH_G:    return CH_R;
            CH_R:    return CH_B;
            default: return CH_G;
        endcase
    endfunction

    function automatic pixel_grb_t write_channel(input pixel_grb_t px,
                                                 input chan_t      ch,
                                                 input logic [7:0] value);
        pixel_grb_t res;
        res = px;
        case (ch)
            CH_G:    res.g = value;
            CH_R:    res.r = value;
            CH_B:    res.b = value;
            default: res = px;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/frame_gap_timer.sv
// Inter-frame gap down-counter.
//   clock, reset : system clock, asynchronous active-low reset
//   load         : load FRAME_GAP-1 (takes priority over dec)
//   dec          : decrement, saturating at zero
//   zero         : terminal count reached
module frame_gap_timer #(
    parameter int FRAME_GAP = 1250000
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    input  logic dec,
    output logic zero
);

    // FRAME_GAP == 1 still needs a one-bit register.
    localparam int W = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = W'(FRAME_GAP - 1);
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/pattern_frame_loader.sv
// Pattern frame loader: walks the colour-pattern generator's step arrays one
// entry per frame, builds a GRB frame buffer and offers each updated frame to
// the NeoPixel serializer over valid/ready, pacing steps with a gap timer.
//   clock, reset   : system clock, asynchronous active-low reset
//   enable         : run the sequence; low parks in IDLE at the next step boundary
//   color_array    : intensity byte per step
//   pixel_array    : target pixel per step (values >= NUM_PIXELS write nothing)
//   max_num_loads  : steps per pattern cycle before clear and wrap
//   frame_data     : frame buffer, pixel p at [p*24+23:p*24], G in the top byte
//   frame_valid    : frame offered to the serializer
//   frame_ready    : serializer accepts the frame
//   load_index     : current step index
//   pattern_wrap   : one-cycle pulse when the index wraps to 0
//   freeze         : (LOADER_FREEZE_EN only) keep re-sending the current frame
// Build option: define LOADER_FREEZE_EN to add the freeze input.
//
// state | meaning
// IDLE  | parked, waiting for enable
// LOAD  | write this step's byte into the buffer, sample the step limit
// SEND  | frame offered; wait for frame_ready
// GAP   | inter-frame gap countdown, then advance or wrap
// CLEAR | pattern wrapped; zero the buffer
module pattern_frame_loader
    import pattern_loader_pkg::*;
#(
    parameter int NUM_PIXELS = 5,
    parameter int FRAME_GAP  = 1250000
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            enable,
    input  logic [NUM_ENTRIES-1:0][7:0]     color_array,
    input  logic [NUM_ENTRIES-1:0][2:0]     pixel_array,
    input  logic [6:0]                      max_num_loads,
`ifdef LOADER_FREEZE_EN
    input  logic                            freeze,
`endif
    output logic [NUM_PIXELS*24-1:0]        frame_data,
    output logic                            frame_valid,
    input  logic                            frame_ready,
    output logic [5:0]                      load_index,
    output logic                            pattern_wrap
);

    state_t                        state_q, state_d;
    chan_t                         chan_q, chan_d;
    logic [5:0]                    load_index_q, load_index_d;
    logic [6:0]                    limit_q, limit_d;
    logic                          pattern_wrap_q, pattern_wrap_d;
    logic                          frame_valid_q, frame_valid_d;
    pixel_grb_t [NUM_PIXELS-1:0]   frame_q, frame_d;

    logic [2:0]                    sel_pixel;
    logic [7:0]                    sel_color;
    logic [6:0]                    index_plus1;
    logic                          gap_load;
    logic                          gap_dec;
    logic                          gap_zero;
    logic                          hold_frame;

`ifdef LOADER_FREEZE_EN
    assign hold_frame = freeze;
`else
    assign hold_frame = 1'b0;
`endif

    assign sel_pixel   = pixel_array[load_index_q];
    assign sel_color   = color_array[load_index_q];
    assign index_plus1 = {1'b0, load_index_q} + 7'd1;

    always_comb begin
        state_d        = state_q;
        chan_d         = chan_q;
        load_index_d   = load_index_q;
        limit_d        = limit_q;
        frame_d        = frame_q;
        pattern_wrap_d = 1'b0;
        gap_load       = 1'b0;
        gap_dec        = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = LOAD;
                end
            end

            LOAD: begin
                limit_d = effective_limit(max_num_loads);
                // Out-of-range pixel indices match no buffer entry, but the
                // step still rotates the channel.
                for (int p = 0; p < NUM_PIXELS; p++) begin
                    if (sel_pixel == 3'(p)) begin
                        frame_d[p] = write_channel(frame_q[p], chan_q, sel_color);
                    end
                end
                chan_d  = next_chan(chan_q);
                state_d = SEND;
            end

            SEND: begin
                if (frame_ready) begin
                    gap_load = 1'b1;
                    state_d  = GAP;
                end
            end

            GAP: begin
                if (!gap_zero) begin
                    gap_dec = 1'b1;
                end else if (hold_frame) begin
                    // Freeze: refresh the same frame, index untouched.
                    state_d = SEND;
                end else if (index_plus1 >= limit_q) begin
                    // >= also catches a limit that shrank below the index.
                    load_index_d   = '0;
                    chan_d         = CH_G;
                    pattern_wrap_d = 1'b1;
                    state_d        = CLEAR;
                end else begin
                    load_index_d = load_index_q + 6'd1;
                    state_d      = enable ? LOAD : IDLE;
                end
            end

            CLEAR: begin
                frame_d = '0;
                state_d = enable ? LOAD : IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        frame_valid_d = (state_d == SEND);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            chan_q         <= CH_G;
            load_index_q   <= '0;
            limit_q        <= 7'd1;
            pattern_wrap_q <= 1'b0;
            frame_valid_q  <= 1'b0;
            frame_q        <= '0;
        end else begin
            state_q        <= state_d;
            chan_q         <= chan_d;
            load_index_q   <= load_index_d;
            limit_q        <= limit_d;
            pattern_wrap_q <= pattern_wrap_d;
            frame_valid_q  <= frame_valid_d;
            frame_q        <= frame_d;
        end
    end

    frame_gap_timer #(
        .FRAME_GAP (FRAME_GAP)
    ) u_gap_timer (
        .clock (clock),
        .reset (reset),
        .load  (gap_load),
        .dec   (gap_dec),
        .zero  (gap_zero)
    );

    assign frame_data   = frame_q;
    assign frame_valid  = frame_valid_q;
    assign load_index   = load_index_q;
    assign pattern_wrap = pattern_wrap_q;

endmodule

// File: tb/tb_pattern_frame_loader.sv
// Self-checking bench for pattern_frame_loader (default build, short gap).
module tb_pattern_frame_loader;

    localparam int NPIX      = 5;
    localparam int FRAME_GAP = 4;
    localparam int NENT      = 63;

    logic                    clock;
    logic                    reset;
    logic                    enable;
    logic [NENT-1:0][7:0]    color_array;
    logic [NENT-1:0][2:0]    pixel_array;
    logic [6:0]              max_num_loads;
    logic [NPIX*24-1:0]      frame_data;
    logic                    frame_valid;
    logic                    frame_ready;
    logic [5:0]              load_index;
    logic                    pattern_wrap;

    pattern_frame_loader #(
        .NUM_PIXELS (NPIX),
        .FRAME_GAP  (FRAME_GAP)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .color_array   (color_array),
        .pixel_array   (pixel_array),
        .max_num_loads (max_num_loads),
        .frame_data    (frame_data),
        .frame_valid   (frame_valid),
        .frame_ready   (frame_ready),
        .load_index    (load_index),
        .pattern_wrap  (pattern_wrap)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model: bytes per pixel per channel -------------
    logic [7:0] m_buf [NPIX][3];
    int m_idx, m_chan, m_lim;

    function automatic int eff_limit(input int m);
        if (m == 0) return 1;
        if (m > NENT) return NENT;
        return m;
    endfunction

    task automatic model_reset();
        for (int p = 0; p < NPIX; p++)
            for (int c = 0; c < 3; c++) m_buf[p][c] = 8'h00;
        m_idx = 0; m_chan = 0; m_lim = 1;
    endtask

    function automatic logic [NPIX*24-1:0] model_frame();
        logic [NPIX*24-1:0] f;
        f = '0;
        for (int p = 0; p < NPIX; p++) f[p*24 +: 24] = {m_buf[p][0], m_buf[p][1], m_buf[p][2]};
        return f;
    endfunction

    task automatic model_load();
        int p;
        p = int'(pixel_array[m_idx]);
        if (p < NPIX) m_buf[p][m_chan] = color_array[m_idx];
        m_chan = (m_chan + 1) % 3;
        m_lim  = eff_limit(int'(max_num_loads));
    endtask

    function automatic bit model_advance();
        if (m_idx + 1 >= m_lim) begin
            m_idx = 0; m_chan = 0;
            for (int p = 0; p < NPIX; p++)
                for (int c = 0; c < 3; c++) m_buf[p][c] = 8'h00;
            return 1'b1;
        end
        m_idx++;
        return 1'b0;
    endfunction

    task automatic randomize_arrays();
        for (int i = 0; i < NENT; i++) begin
            color_array[i] = 8'($urandom);
            pixel_array[i] = 3'($urandom_range(0, 7));
        end
    endtask

    // One full step: wait for the offered frame, check it, hold off `hold`
    // cycles, accept, then check the gap length and the advance / wrap.
    // `wrapped` reports what the DUT's pattern_wrap showed at gap end.
    task automatic step_check(input string tag, input int hold, input bit drop_en,
                              output bit wrapped, output logic [NPIX*24-1:0] seen);
        int         n;
        logic [5:0] old_idx;
        bit         exp_wrap;
        n = 0; wrapped = 1'b0; seen = '0;
        while (frame_valid !== 1'b1 && n < 40) begin
            @(posedge clock); #1; n++;
        end
        if (frame_valid !== 1'b1) begin
            check($sformatf("%s valid timeout", tag), {127'd0, frame_valid}, 128'd1);
            frame_ready = 1'b1;
            return;
        end
        model_load();
        seen = frame_data;
        check($sformatf("%s data", tag), frame_data, model_frame());
        check($sformatf("%s index", tag), load_index, m_idx);
        if (drop_en) enable = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clock); #1;
            check($sformatf("%s hold", tag), {frame_valid, frame_data}, {1'b1, model_frame()});
        end
        frame_ready = 1'b1;
        @(posedge clock); #1;
        check($sformatf("%s valid drop", tag), {127'd0, frame_valid}, 128'd0);
        old_idx  = 6'(m_idx);
        exp_wrap = model_advance();
        repeat (FRAME_GAP - 1) @(posedge clock);
        #1;
        check($sformatf("%s gap early", tag), {frame_valid, pattern_wrap, load_index},
              {1'b0, 1'b0, old_idx});
        @(posedge clock); #1;
        wrapped = pattern_wrap;
        check($sformatf("%s gap end", tag), {pattern_wrap, load_index}, {exp_wrap, 6'(m_idx)});
        if (exp_wrap) begin
            @(posedge clock); #1;
            check($sformatf("%s clear", tag), {pattern_wrap, frame_data}, {1'b0, 120'd0});
        end
    endtask

    typedef struct {
        logic [6:0] mnl;
        int         exp_steps;
    } clamp_vec_t;

    clamp_vec_t          clamp_tbl [8];
    bit                  wr;
    logic [NPIX*24-1:0]  seen;
    int                  steps;
    int                  n;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        clamp_tbl[0] = '{7'd0,   1};
        clamp_tbl[1] = '{7'd1,   1};
        clamp_tbl[2] = '{7'd2,   2};
        clamp_tbl[3] = '{7'd62,  62};
        clamp_tbl[4] = '{7'd63,  63};
        clamp_tbl[5] = '{7'd64,  63};
        clamp_tbl[6] = '{7'd100, 63};
        clamp_tbl[7] = '{7'd127, 63};

        reset = 1'b0; enable = 1'b0; frame_ready = 1'b1; max_num_loads = 7'd1;
        randomize_arrays();
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        check("reset valid", {127'd0, frame_valid}, 128'd0);
        check("reset data",  frame_data, 128'd0);
        check("reset index", load_index, 128'd0);
        check("reset wrap",  {127'd0, pattern_wrap}, 128'd0);

        // Start: one-step pattern, pixel 2 gets G=0x16.
        reset = 1'b1;
        pixel_array[0] = 3'd2; color_array[0] = 8'h16;
        @(posedge clock); #1;
        enable = 1'b1;
        @(posedge clock); #1;
        check("start latency c1", {127'd0, frame_valid}, 128'd0);
        @(posedge clock); #1;
        check("start latency c2", {127'd0, frame_valid}, 128'd1);
        step_check("start", 0, 1'b0, wr, seen);
        check("start pixel2", seen[71:48], 24'h160000);

        // Channel rotation and wrap: three steps on pixel 1, limit 3.
        pixel_array[0] = 3'd1; color_array[0] = 8'h10;
        pixel_array[1] = 3'd1; color_array[1] = 8'h05;
        pixel_array[2] = 3'd1; color_array[2] = 8'h20;
        max_num_loads = 7'd3;
        steps = 0;
        for (int s = 0; s < 3; s++) begin
            step_check($sformatf("rot%0d", s), 0, 1'b0, wr, seen);
            steps += int'(wr);
        end
        check("rot pixel1", seen[47:24], 24'h100520);
        check("rot wrap count", steps, 1);
        check("rot wrapped index", load_index, 0);

        // Out-of-range pixel: no write, but the channel still advances.
        pixel_array[0] = 3'd7; color_array[0] = 8'hAA;
        pixel_array[1] = 3'd0; color_array[1] = 8'h33;
        max_num_loads = 7'd2;
        step_check("pix7", 0, 1'b0, wr, seen);
        check("pix7 no change", seen, 128'd0);
        step_check("pix7 next", 0, 1'b0, wr, seen);
        check("pix7 next chan R", seen[23:0], 24'h003300);

        // Limit clamps, table driven: steps until the DUT pulses pattern_wrap.
        for (int k = 0; k < 8; k++) begin
            max_num_loads = clamp_tbl[k].mnl;
            randomize_arrays();
            steps = 0; wr = 1'b0;
            while (!wr && steps < 70) begin
                step_check($sformatf("clamp%0d", clamp_tbl[k].mnl), 0, 1'b0, wr, seen);
                steps++;
            end
            check($sformatf("clamp%0d steps", clamp_tbl[k].mnl), steps, clamp_tbl[k].exp_steps);
        end

        // Limit shrinks below the index mid-pattern: wrap at the next gap exit.
        max_num_loads = 7'd10;
        randomize_arrays();
        for (int s = 0; s < 4; s++) step_check("shrink pre", 0, 1'b0, wr, seen);
        max_num_loads = 7'd2;
        step_check("shrink", 0, 1'b0, wr, seen);
        check("shrink wrap", {127'd0, wr}, 128'd1);

        // enable dropped during SEND: frame completes, then park in IDLE.
        max_num_loads = 7'd10;
        step_check("en drop", 0, 1'b1, wr, seen);
        repeat (6) @(posedge clock);
        #1;
        check("idle parked", {frame_valid, load_index}, {1'b0, 6'd1});
        enable = 1'b1;
        @(posedge clock); #1;
        check("resume latency c1", {127'd0, frame_valid}, 128'd0);
        @(posedge clock); #1;
        check("resume latency c2", {127'd0, frame_valid}, 128'd1);
        step_check("resume", 0, 1'b0, wr, seen);

        // Backpressure: ready low for 10 SEND cycles, accept on the 11th.
        frame_ready = 1'b0;
        step_check("bp", 10, 1'b0, wr, seen);
        max_num_loads = 7'd3;
        step_check("bp wrap", 0, 1'b0, wr, seen);

        // Asynchronous reset in the middle of a SEND.
        pixel_array[0] = 3'd3; color_array[0] = 8'h5A;
        frame_ready = 1'b0;
        n = 0;
        while (frame_valid !== 1'b1 && n < 40) begin
            @(posedge clock); #1; n++;
        end
        check("areset pre valid", {127'd0, frame_valid}, 128'd1);
        check("areset pre pixel3", frame_data[95:72], 24'h5A0000);
        #3;
        reset = 1'b0;
        #1;
        check("areset valid", {127'd0, frame_valid}, 128'd0);
        check("areset data", frame_data, 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
